// File: rtl/seq_div_pkg.sv
// Shared defaults, counter sizing and FSM state type for the sequential divider.
package seq_div_pkg;

    localparam int DIVIDEND_W_DEF = 12;
    localparam int DIVISOR_W_DEF  = 6;
    localparam int CNT_W          = $clog2(DIVIDEND_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module restoring_div_step #(
    parameter int DIVISOR_W = 6
) (
    input  logic [DIVISOR_W:0]   pr,
    input  logic                 q_msb,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   next_pr,
    output logic                 q_bit
);

    // pr is always below the divisor, so its top bit is zero and the wide
    // shift equals {pr[DIVISOR_W-1:0], q_msb}; using the full pr keeps every
    // input bit live.
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] diff;

    // Shift-in, trial subtract and restore select.
    always_comb begin
        shifted = {pr, q_msb};
        diff    = shifted - {2'b00, divisor};
        q_bit   = (shifted >= {2'b00, divisor});
        next_pr = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/seq_unsigned_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional build macro: SEQ_DIV_EARLY_EXIT_EN (fast path when dividend < divisor).
module seq_unsigned_divider
    import seq_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CW = $clog2(DIVIDEND_W);

    state_t                state, next_state;
    logic [DIVIDEND_W-1:0] q;
    logic [DIVISOR_W:0]    pr;
    logic [DIVISOR_W-1:0]  dvs;
    logic [CW-1:0]         cnt;
    logic                  fast;
    logic                  fast_dz;

    logic                  accept;
    logic                  fast_take;
    logic [DIVISOR_W:0]    step_pr;
    logic                  step_bit;
    logic [DIVIDEND_W-1:0] q_shifted;

    restoring_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .pr      (pr),
        .q_msb   (q[DIVIDEND_W-1]),
        .divisor (dvs),
        .next_pr (step_pr),
        .q_bit   (step_bit)
    );

    // Acceptance and fast-path qualification of the incoming operands.
    always_comb begin
        accept    = start && (state != RUN);
        q_shifted = {q[DIVIDEND_W-2:0], step_bit};
`ifdef SEQ_DIV_EARLY_EXIT_EN
        fast_take = (divisor == '0) || (dividend < DIVIDEND_W'(divisor));
`else
        fast_take = (divisor == '0);
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic and status outputs.
    always_comb begin
        next_state = state;
        busy       = (state == RUN);
        done       = (state == DONE);
        case (state)
            IDLE, DONE: next_state = start ? RUN : IDLE;
            RUN:        if (cnt == '0) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and result registers.
    // Fast paths spend a single RUN cycle with cnt=0 so their results land
    // one edge after acceptance, the same timing as a one-step division.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q           <= '0;
            pr          <= '0;
            dvs         <= '0;
            cnt         <= '0;
            fast        <= 1'b0;
            fast_dz     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q           <= dividend;
            pr          <= '0;
            dvs         <= divisor;
            div_by_zero <= 1'b0;
            fast        <= fast_take;
            fast_dz     <= (divisor == '0);
            cnt         <= fast_take ? '0 : CW'(DIVIDEND_W - 1);
        end else if (state == RUN) begin
            if (fast) begin
                quotient    <= fast_dz ? '1 : '0;
                remainder   <= q[DIVISOR_W-1:0];
                div_by_zero <= fast_dz;
            end else begin
                q  <= q_shifted;
                pr <= step_pr;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    quotient  <= q_shifted;
                    remainder <= step_pr[DIVISOR_W-1:0];
                end
            end
        end
    end

endmodule
